// File: rtl/shift_register_enable_pkg.sv
// shift_register_enable_pkg: op encodings and control-word field positions for shift_register_enable
package shift_register_enable_pkg;
  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_SLL   = 3'b001;
  localparam logic [2:0] OP_SRL   = 3'b010;
  localparam logic [2:0] OP_SRA   = 3'b011;
  localparam logic [2:0] OP_ROL   = 3'b100;
  localparam logic [2:0] OP_ROR   = 3'b101;
  localparam logic [2:0] OP_CLEAR = 3'b110;
  localparam logic [2:0] OP_RSVD  = 3'b111;
  localparam int EN_BIT    = 0;
  localparam int OP_LSB    = 1;
  localparam int OP_MSB    = 3;
  localparam int SHAMT_LSB = 4;
  localparam int SHAMT_MSB = 8;
  localparam int SRC_BIT   = 9;
endpackage

// File: rtl/shift_register_enable_barrel.sv
// shift_register_enable_barrel: combinational log shifter (SLL/SRL/SRA; ROL/ROR with SHIFT_REG_ROTATE_EN)
module shift_register_enable_barrel
  import shift_register_enable_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] s,
  input  logic [SW-1:0]    shamt,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] result
);
  logic [WIDTH-1:0] st [0:SW];
  logic left, sra;
  assign sra = op == OP_SRA;
`ifdef SHIFT_REG_ROTATE_EN
  logic rot;
  assign rot  = op == OP_ROL || op == OP_ROR;
  assign left = op == OP_SLL || op == OP_ROL;
`else
  assign left = op == OP_SLL;
`endif
  assign st[0] = s;
  for (genvar k = 0; k < SW; k++) begin : g_stage
    localparam int N = 1 << k;
    logic [WIDTH-1:0] l_v, r_v;
`ifdef SHIFT_REG_ROTATE_EN
    assign l_v = {st[k][WIDTH-1-N:0], rot ? st[k][WIDTH-1:WIDTH-N] : {N{1'b0}}};
    assign r_v = {rot ? st[k][N-1:0] : {N{sra & s[WIDTH-1]}}, st[k][WIDTH-1:N]};
`else
    assign l_v = {st[k][WIDTH-1-N:0], {N{1'b0}}};
    assign r_v = {{N{sra & s[WIDTH-1]}}, st[k][WIDTH-1:N]};
`endif
    assign st[k+1] = shamt[k] ? (left ? l_v : r_v) : st[k];
  end
  assign result = st[SW];
endmodule

// File: rtl/shift_register_enable.sv
// shift_register_enable: enabled 32-bit register with load/shift/clear datapath; rotates under SHIFT_REG_ROTATE_EN
module shift_register_enable
  import shift_register_enable_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] dataIn,
  input  logic [31:0]      control,
  output logic [WIDTH-1:0] dataOut
);
  localparam int SW = $clog2(WIDTH);
  logic             en, src, shift_op;
  logic [2:0]       op;
  logic [SW-1:0]    shamt;
  logic [WIDTH-1:0] s, result, nxt;
  logic             unused_rsvd;
  assign en          = control[EN_BIT];
  assign op          = control[OP_MSB:OP_LSB];
  assign shamt       = control[SHAMT_LSB +: SW];
  assign src         = control[SRC_BIT];
  assign unused_rsvd = ^control[31:SRC_BIT+1];
  assign s           = src ? dataIn : dataOut;
`ifdef SHIFT_REG_ROTATE_EN
  assign shift_op = op inside {OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR};
`else
  assign shift_op = op inside {OP_SLL, OP_SRL, OP_SRA};
`endif
  shift_register_enable_barrel #(.WIDTH(WIDTH), .SW(SW)) u_barrel (
    .s      (s),
    .shamt  (shamt),
    .op     (op),
    .result (result)
  );
  // unused/reserved ops fall through to hold
  assign nxt = op == OP_LOAD ? dataIn : op == OP_CLEAR ? '0 : shift_op ? result : dataOut;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) dataOut <= '0;
    else if (en) dataOut <= nxt;
endmodule

// File: tb/tb_shift_register_enable.sv
// tb_shift_register_enable: directed plus randomized checks against a behavioural model
module tb_shift_register_enable;
  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [31:0] dataIn = '0;
  logic [31:0] control = '0;
  logic [31:0] dataOut;
  logic [31:0] model = '0;
  int checks = 0;
  int errors = 0;

  shift_register_enable dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .dataIn  (dataIn),
    .control (control),
    .dataOut (dataOut)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ctl(input int op, input int sh, input bit src, input bit en = 1'b1);
    logic [31:0] c;
    c = '0;
    c[0] = en;
    c[3:1] = 3'(op);
    c[8:4] = 5'(sh);
    c[9] = src;
    return c;
  endfunction

  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] d, input logic [31:0] c);
    logic [31:0] s;
    logic signed [31:0] ss;
    logic [63:0] dbl;
    int n;
    n = int'(c[8:4]);
    s = c[9] ? d : cur;
    ss = s;
    dbl = {s, s};
    if (!c[0]) return cur;
    case (int'(c[3:1]))
      0: return d;
      1: return s << n;
      2: return s >> n;
      3: return ss >>> n;
`ifdef SHIFT_REG_ROTATE_EN
      4: begin dbl = dbl << n; return dbl[63:32]; end
      5: begin dbl = dbl >> n; return dbl[31:0]; end
`endif
      6: return 32'h0;
      default: return cur;
    endcase
  endfunction

  task automatic step(input logic [31:0] c, input logic [31:0] d);
    @(negedge CLK);
    control = c;
    dataIn = d;
    @(posedge CLK);
    model = RST_N ? model_next(model, d, c) : 32'h0;
    #1;
  endtask

  task automatic run(input string tag, input logic [31:0] c, input logic [31:0] d, input logic [31:0] exp);
    step(c, d);
    check(tag, dataOut, exp);
  endtask

  initial begin
    dataIn = 32'hFFFF_FFFF;
    control = 32'h1;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      #1;
      check("reset_hold", dataOut, 32'h0);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    run("load_before_async", ctl(0, 0, 0), 32'h1234_5678, 32'h1234_5678);
    control = 32'h0;
    #(100 - $time);
    RST_N = 1'b0;
    #2;
    check("async_clear", dataOut, 32'h0);
    model = 32'h0;
    #1;
    RST_N = 1'b1;

    run("load", ctl(0, 0, 0), 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    run("hold_en0", ctl(0, 0, 0, 1'b0), 32'h0BAD_F00D, 32'hDEAD_BEEF);
    run("reload1", ctl(0, 0, 0), 32'h8000_0001, 32'h8000_0001);
    run("sll4", ctl(1, 4, 0), 32'hFFFF_FFFF, 32'h0000_0010);
    run("reload2", ctl(0, 0, 0), 32'h8000_0001, 32'h8000_0001);
    run("srl31", ctl(2, 31, 0), 32'hFFFF_FFFF, 32'h0000_0001);
    run("reload3", ctl(0, 0, 0), 32'h8000_0001, 32'h8000_0001);
    run("sra4", ctl(3, 4, 0), 32'h0, 32'hF800_0000);
    run("srl4_src", ctl(2, 4, 1), 32'h0000_00F0, 32'h0000_000F);
    run("sll0", ctl(1, 0, 0), 32'h5555_5555, 32'h0000_000F);
    run("sra0_src", ctl(3, 0, 1), 32'h9ABC_DEF0, 32'h9ABC_DEF0);
    run("srl0", ctl(2, 0, 0), 32'h0, 32'h9ABC_DEF0);
    run("reload4", ctl(0, 0, 0), 32'h8000_0001, 32'h8000_0001);
`ifdef SHIFT_REG_ROTATE_EN
    run("rol1", ctl(4, 1, 0), 32'h0, 32'h0000_0003);
    run("reload5", ctl(0, 0, 0), 32'h8000_0001, 32'h8000_0001);
    run("ror1", ctl(5, 1, 0), 32'h0, 32'hC000_0000);
    run("rsvd_hold", ctl(7, 3, 1), 32'h1111_1111, 32'hC000_0000);
`else
    run("op4_hold", ctl(4, 1, 0), 32'h2222_2222, 32'h8000_0001);
    run("op5_hold", ctl(5, 1, 1), 32'h3333_3333, 32'h8000_0001);
    run("op7_hold", ctl(7, 1, 0), 32'h4444_4444, 32'h8000_0001);
`endif
    run("clear", ctl(6, 7, 1), 32'hFFFF_FFFF, 32'h0);
    run("load_rsvd_bits", ctl(0, 0, 0) | 32'hFFFF_FC00, 32'hCAFE_F00D, 32'hCAFE_F00D);
    run("load_rsvd_fields", ctl(0, 31, 1) | 32'hFFFF_FC00, 32'h0123_4567, 32'h0123_4567);

    model = dataOut === 32'h0123_4567 ? 32'h0123_4567 : model;
    for (int i = 0; i < 400; i++) begin
      logic [31:0] c, d;
      c = $urandom;
      d = $urandom;
      if ($urandom_range(0, 3) != 0) c[0] = 1'b1;
      if ($urandom_range(0, 39) == 0) begin
        @(negedge CLK);
        RST_N = 1'b0;
        #1;
        check("rand_async", dataOut, 32'h0);
        model = 32'h0;
        step(c, d);
        check("rand_reset_edge", dataOut, 32'h0);
        @(negedge CLK);
        RST_N = 1'b1;
      end else begin
        step(c, d);
        check("rand", dataOut, model);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
